// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: buffers one stereo pair and shifts it out MSB-first in I2S framing.
// Optional macro I2S_TX_REPEAT_EN replays the last active pair on underrun instead of sending zeros.
module i2s_tx_serializer #(
  parameter int WIDTH     = 8,
  parameter int SLOT_BITS = 16
) (
  input  logic             sck,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] in_left,
  input  logic [WIDTH-1:0] in_right,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ws,
  output logic             sd,
  output logic             underrun
);
  localparam int CW = $clog2(2 * SLOT_BITS);
  localparam logic [CW-1:0] LAST    = CW'(2 * SLOT_BITS - 1);
  localparam logic [CW-1:0] SLOT    = CW'(SLOT_BITS);
  localparam logic [CW-1:0] WID     = CW'(WIDTH);
  localparam logic [CW-1:0] RGT_END = CW'(SLOT_BITS + WIDTH);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ws_q, ws_d, sd_q, sd_d, ur_q, ur_d, full_q, full_d;
  logic [WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [WIDTH-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
  logic [WIDTH-1:0] sh_l, sh_r;
  logic             wrap, accept, bit_k;

  assign in_ready = ~full_q;
  assign ws       = ws_q;
  assign sd       = sd_q;
  assign underrun = ur_q;

  // Next-state: frame counter, registered ws/sd one bit behind cnt, handshake and frame reload.
  always_comb begin
    accept   = in_valid && !full_q;
    wrap     = en && (cnt_q == LAST);
    cnt_d    = (!en || wrap) ? '0 : cnt_q + 1'b1;
    sh_l     = act_l_q << cnt_q;
    sh_r     = act_r_q << (cnt_q - SLOT);
    bit_k    = (cnt_q < WID) ? sh_l[WIDTH-1] :
               (cnt_q >= SLOT && cnt_q < RGT_END) ? sh_r[WIDTH-1] : 1'b0;
    ws_d     = en && (cnt_d >= SLOT);
    sd_d     = en && bit_k;
    ur_d     = wrap && !full_q;
    hold_l_d = accept ? in_left : hold_l_q;
    hold_r_d = accept ? in_right : hold_r_q;
    full_d   = accept || (full_q && !wrap);
    act_l_d  = act_l_q;
    act_r_d  = act_r_q;
    if (wrap && full_q) begin
      act_l_d = hold_l_q;
      act_r_d = hold_r_q;
    end
`ifdef I2S_TX_REPEAT_EN
`else
    else if (wrap) begin
      act_l_d = '0;
      act_r_d = '0;
    end
`endif
  end

  // State registers, cleared asynchronously by the active-low reset.
  always_ff @(posedge sck or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      ws_q     <= 1'b0;
      sd_q     <= 1'b0;
      ur_q     <= 1'b0;
      full_q   <= 1'b0;
      hold_l_q <= '0;
      hold_r_q <= '0;
      act_l_q  <= '0;
      act_r_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      ws_q     <= ws_d;
      sd_q     <= sd_d;
      ur_q     <= ur_d;
      full_q   <= full_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      act_l_q  <= act_l_d;
      act_r_q  <= act_r_d;
    end
  end
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb_i2s_tx_serializer: directed scoreboard bench for the I2S transmit serializer.
module tb_i2s_tx_serializer;
  logic       sck = 1'b0;
  logic       rst, en, in_valid, in_ready, ws, sd, underrun;
  logic [7:0] in_left, in_right;

  typedef struct packed {logic ws; logic sd; logic ur; logic rdy;} exp_t;
  exp_t q[$];

  int         checks = 0, errors = 0, mc = 0, dacc = 0;
  logic [7:0] act_l = 0, act_r = 0, hold_l = 0, hold_r = 0, cap_l = 0, cap_r = 0, pl, pr;
  logic       hold_full = 1'b0, a;

  i2s_tx_serializer #(.WIDTH(8), .SLOT_BITS(16)) dut (
    .sck(sck), .rst(rst), .en(en), .in_left(in_left), .in_right(in_right),
    .in_valid(in_valid), .in_ready(in_ready), .ws(ws), .sd(sd), .underrun(underrun)
  );

  always #5 sck = ~sck;

  function automatic logic bit_of(input int k, input logic [7:0] l, input logic [7:0] r);
    if (k < 8) return l[7-k];
    if (k >= 16 && k < 24) return r[23-k];
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp();
    exp_t e;
    if (q.size() == 0) begin
      chk("queue_empty", 32'(q.size()), 1);
      return;
    end
    e = q.pop_front();
    chk("ws", ws, e.ws);
    chk("sd", sd, e.sd);
    chk("underrun", underrun, e.ur);
    chk("in_ready", in_ready, e.rdy);
    if (mc >= 1 && mc <= 8) cap_l = {cap_l[6:0], sd};
    if (mc >= 17 && mc <= 24) cap_r = {cap_r[6:0], sd};
  endtask

  task automatic step(input logic e_n, input logic v_n, input logic [7:0] l, input logic [7:0] r,
                      output logic acc);
    logic wrap, u;
    int   mn;
    exp_t n;
    cmp();
    en = e_n; in_valid = v_n; in_left = l; in_right = r;
    acc  = v_n && !hold_full;
    wrap = e_n && mc == 31;
    mn   = !e_n ? 0 : (mc == 31 ? 0 : mc + 1);
    u    = 1'b0;
    if (wrap && hold_full) begin
      act_l = hold_l; act_r = hold_r; hold_full = 1'b0;
    end else if (wrap) begin
      u = 1'b1;
`ifndef I2S_TX_REPEAT_EN
      act_l = 8'h00; act_r = 8'h00;
`endif
    end
    if (acc) begin
      hold_l = l; hold_r = r; hold_full = 1'b1;
    end
    n.ws  = e_n && mn >= 16;
    n.sd  = (e_n && mn != 0) ? bit_of(mn - 1, act_l, act_r) : 1'b0;
    n.ur  = u;
    n.rdy = !hold_full;
    q.push_back(n);
    mc = mn;
    @(negedge sck);
  endtask

  task automatic run(input int cnt, input logic e_n, input logic v_n, input logic [7:0] l,
                     input logic [7:0] r);
    logic x;
    repeat (cnt) step(e_n, v_n, l, r, x);
  endtask

  task automatic restart();
    exp_t n;
    n = '{ws: 1'b0, sd: 1'b0, ur: 1'b0, rdy: 1'b1};
    q.delete();
    mc = 0; act_l = 0; act_r = 0; hold_full = 1'b0; cap_l = 0; cap_r = 0;
    @(negedge sck);
    rst = 1'b1;
    q.push_back(n);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_left = 8'h00; in_right = 8'h00;
    #1 rst = 1'b0;
    @(negedge sck);
    chk("reset_ws", ws, 0);
    chk("reset_sd", sd, 0);
    chk("reset_underrun", underrun, 0);
    chk("reset_in_ready", in_ready, 1);
    en = 1'b1;
    restart();
    // idle frames: zeros, underrun at every wrap
    run(64, 1, 0, 8'h00, 8'h00);
    // single pair accepted mid-frame, sent in the next frame
    run(3, 1, 0, 8'h00, 8'h00);
    step(1, 1, 8'hA5, 8'h3C, a);
    chk("ready_drop", in_ready, 0);
    run(28, 1, 0, 8'h00, 8'h00);
    run(32, 1, 0, 8'h00, 8'h00);
    chk("left_bits_a5", cap_l, 8'hA5);
    chk("right_bits_3c", cap_r, 8'h3C);
    // continuous offer: one pair per frame
    pl = 8'h81; pr = 8'h7E; dacc = 0;
    for (int i = 0; i < 128; i++) begin
      if (in_ready) dacc++;
      step(1, 1, pl, pr, a);
      if (a) begin
        pl = pl + 8'h13; pr = pr - 8'h07;
      end
    end
    chk("streaming_accepts", dacc, 4);
    // pair offered on the wrap edge into an empty buffer
    run(31, 1, 0, 8'h00, 8'h00);
    step(1, 1, 8'h5A, 8'hC3, a);
    run(32, 1, 0, 8'h00, 8'h00);
    run(2, 1, 0, 8'h00, 8'h00);
    step(1, 1, 8'hE7, 8'h18, a);
    run(17, 1, 0, 8'h00, 8'h00);
    chk("wrap_pair_left_5a", cap_l, 8'h5A);
    // asynchronous reset mid right slot with a full buffer
    cmp();
    #2 rst = 1'b0;
    #1;
    chk("midframe_rst_ws", ws, 0);
    chk("midframe_rst_sd", sd, 0);
    chk("midframe_rst_in_ready", in_ready, 1);
    chk("midframe_rst_underrun", underrun, 0);
    restart();
    run(32, 1, 0, 8'h00, 8'h00);
    chk("restart_zero_left", cap_l, 8'h00);
    chk("restart_zero_right", cap_r, 8'h00);
    // enable drop at cnt 5, resume re-sends the active pair from its MSB
    run(3, 1, 0, 8'h00, 8'h00);
    step(1, 1, 8'h96, 8'h69, a);
    run(28, 1, 0, 8'h00, 8'h00);
    run(5, 1, 0, 8'h00, 8'h00);
    step(0, 0, 8'h00, 8'h00, a);
    chk("en_off_ws", ws, 0);
    chk("en_off_sd", sd, 0);
    run(9, 0, 0, 8'h00, 8'h00);
    step(1, 0, 8'h00, 8'h00, a);
    run(32, 1, 0, 8'h00, 8'h00);
    chk("resume_left_96", cap_l, 8'h96);
    chk("resume_right_69", cap_r, 8'h69);
    chk("queue_depth", 32'(q.size()), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
- Upstream stage of the I2S mixer core; produces one of the two I2S input streams (sd1 or sd2) plus the word-select.
- Accepts parallel stereo sample pairs through a valid/ready handshake and buffers one pair.
- Serialises each pair MSB-first in standard I2S framing: data is delayed one bit after the ws edge, and left is sent while ws is low.
- Runs entirely in the sck domain, so its ws/sd outputs connect directly to the mixer inputs.

Parameters:
- WIDTH, 8, sample width in bits (two's complement).
- SLOT_BITS, 16, sck cycles per channel slot. Must satisfy SLOT_BITS >= WIDTH+1. Frame length is 2*SLOT_BITS.

Ports:
- sck  in  1  bit clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  run enable.
- in_left  in  WIDTH  left sample.
- in_right  in  WIDTH  right sample.
- in_valid  in  1  sample pair is offered.
- in_ready  out  1  holding buffer is empty.
- ws  out  1  word select (0 = left, 1 = right).
- sd  out  1  serial data.
- underrun  out  1  one-cycle pulse when a frame starts without new data.

Behaviour:
- Reset is asynchronous, active-low, and clears all state at any time, including mid-frame. Reset values:
  - ws=0, sd=0, underrun=0.
  - Counter cnt=0, holding buffer empty (in_ready=1).
  - Active pair = 0/0.
- Frame counter:
  - cnt runs 0..2S-1 (S = SLOT_BITS) and increments each cycle while en=1, wrapping 2S-1 -> 0.
  - While en=0, cnt is held at 0, ws=0, sd=0, and the buffer still accepts data.
- Bit stream: b(k), k=0..2S-1.
  - b(k) for k<WIDTH is active_left[WIDTH-1-k].
  - b(k) for S<=k<S+WIDTH is active_right[WIDTH-1-(k-S)].
  - All other b(k) are 0 (padding).
- Outputs in the cycle where cnt=c (both registered, glitch-free):
  - ws = (c >= S).
  - sd = b((c-1) mod 2S). For c=0, this uses the previous frame's active pair.
- Handshake:
  - in_ready = holding buffer empty.
  - Transfer occurs when in_valid && in_ready at the rising edge: the holding buffer captures in_left/in_right and becomes full.
  - in_left/in_right are ignored when no transfer occurs.
- Frame reload, on the edge where cnt wraps 2S-1 -> 0 with en=1:
  - Holding buffer full: active pair <= holding buffer, buffer becomes empty. in_ready rises in the following cycle.
  - Holding buffer empty: active pair <= 0/0 and underrun=1 for one cycle.
  - A transfer on that same edge into an empty buffer lands in the holding buffer, not the active pair; the underrun pulse still fires.
- Because the buffer is full, in_valid is never accepted while the buffer is full, so a simultaneous accept and reload cannot collide.
- Latency: a pair accepted during frame N is output in frame N+1. Its left MSB appears on sd at cnt=1 of that frame.
- Deasserting en mid-frame aborts the frame. cnt returns to 0 and the active pair is kept; the next reload happens at the next wrap.

Optional Feature:
- Macro: I2S_TX_REPEAT_EN.
- Defined: on underrun, the active pair keeps its previous value (the last sample pair is replayed) instead of loading 0/0. The underrun pulse still fires.
- Undefined: on underrun, 0/0 is loaded as described above.

Test Plan (WIDTH=8, S=16):
- Reset released, en=1, no data -> ws low for cnt 0..15 and high for cnt 16..31. sd=0 throughout. underrun pulses once at each wrap (every 32 cycles).
- Accept L=0xA5, R=0x3C in frame 0 -> in frame 1:
  - sd at cnt 1..8 = 1,0,1,0,0,1,0,1.
  - sd at cnt 17..24 = 0,0,1,1,1,1,0,0.
  - sd=0 at cnt 0, cnt 9..16 and cnt 25..31. No underrun at the frame 1 wrap.
- in_valid held high with a new pair every opportunity -> in_ready drops after each accept and rises one cycle after each wrap. Exactly one pair is consumed per 32-cycle frame, with no underrun pulses.
- Pair offered exactly on the wrap edge with the buffer empty -> underrun pulses, that frame outputs zeros (or repeats the last pair with I2S_TX_REPEAT_EN), and the pair is output in the next frame.
- rst asserted at cnt=20 mid-right-slot -> ws=0, sd=0 and in_ready=1 immediately. After release, output restarts at cnt=0 with zeros.
- en dropped at cnt=5, then raised 10 cycles later -> ws/sd=0 while en=0. Framing resumes from cnt=0 and the previously active pair is re-sent from its MSB.
